register_file: RTL and testbench

- 32-entry × 32-bit general-purpose register file for the datapath.
- One synchronous write port and two independent asynchronous (combinational) read ports.
- Sits between instruction decode (register specifiers) and the ALU/writeback stage.
- All 32 entries, including entry 0, are ordinary writable storage; there is no hardwired-zero register.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/register_file.sv | 37 +++
 tb/tb_register_file.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared sizing constants and word/specifier types for the datapath register file.
// Bit 0 is the MSB of every word and specifier.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [0:DATA_W-1] reg_word_t;
  typedef logic [0:ADDR_W-1] reg_addr_t;

endpackage

// File: rtl/register_file.sv
// 32x32 register file: one synchronous write port, two combinational read ports.
// Reads see the pre-edge value during a same-address write; no bypass path.
module register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic [0:DATA_W-1] reg_data,
  input  logic [0:ADDR_W-1] register_no,
  input  logic [0:ADDR_W-1] readReg1,
  input  logic [0:ADDR_W-1] readReg2,
  output logic [0:DATA_W-1] readData1,
  output logic [0:DATA_W-1] readData2
);

  // Entry 0 is ordinary storage; NUM_REGS is expected to equal 2**ADDR_W.
  logic [0:DATA_W-1] r_mem [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (write) begin
      r_mem[register_no] <= reg_data;
    end
  end

  assign readData1 = r_mem[readReg1];
  assign readData2 = r_mem[readReg2];

endmodule

// File: tb/tb_register_file.sv
// Randomized and directed bench for register_file against an array-based reference.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write;
  logic [0:31] reg_data;
  logic [0:4]  register_no;
  logic [0:4]  readReg1;
  logic [0:4]  readReg2;
  logic [0:31] readData1;
  logic [0:31] readData2;

  logic [31:0] model [32];
  int          n_vec  = 0;
  int          n_miss = 0;

  register_file dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .write       (write),
    .reg_data    (reg_data),
    .register_no (register_no),
    .readReg1    (readReg1),
    .readReg2    (readReg2),
    .readData1   (readData1),
    .readData2   (readData2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the write lands on the next rising edge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    write       = 1'b1;
    register_no = a;
    reg_data    = d;
    @(posedge clk);
    model[a] = d;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2, input string tag);
    readReg1 = a1;
    readReg2 = a2;
    #1;
    chk({tag, "_p1"}, readData1, model[a1]);
    chk({tag, "_p2"}, readData2, model[a2]);
  endtask

  initial begin
    rst_n       = 1'b0;
    write       = 1'b0;
    reg_data    = '0;
    register_no = '0;
    readReg1    = 5'd0;
    readReg2    = 5'd31;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Reset is visible combinationally, before any clock edge.
    #2;
    chk("rst_hold_p1", readData1, 32'h0);
    chk("rst_hold_p2", readData2, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rel_p1", readData1, 32'h0);
    chk("rst_rel_p2", readData2, 32'h0);
    @(negedge clk);

    for (int k = 1; k < 32; k++) wr(5'(k), 32'(k));
    for (int k = 0; k < 32; k++) begin
      readReg1 = 5'(k);
      readReg2 = 5'(31 - k);
      #1;
      chk("fill_p1", readData1, 32'(k));
      chk("fill_p2", readData2, 32'(31 - k));
    end
    @(negedge clk);

    wr(5'd0, 32'h39CE7F9E);
    wr(5'd1, 32'hC0100420);
    readReg1 = 5'd0;
    readReg2 = 5'd1;
    #1;
    chk("ovr_r0", readData1, 32'h39CE7F9E);
    chk("ovr_r1", readData2, 32'hC0100420);
    readReg1 = 5'd2;
    #1;
    chk("ovr_r2", readData1, 32'h2);
    @(negedge clk);

    write       = 1'b0;
    register_no = 5'd5;
    reg_data    = 32'hFFFFFFFF;
    repeat (4) @(posedge clk);
    @(negedge clk);
    readReg1 = 5'd5;
    readReg2 = 5'd5;
    #1;
    chk("wdis_p1", readData1, 32'h5);
    chk("wdis_p2", readData2, 32'h5);

    // Same-address read-during-write: old value before the edge, new after.
    @(negedge clk);
    readReg1    = 5'd7;
    readReg2    = 5'd7;
    write       = 1'b1;
    register_no = 5'd7;
    reg_data    = 32'hDEADBEEF;
    #1;
    chk("rdw_pre_p1", readData1, 32'h7);
    chk("rdw_pre_p2", readData2, 32'h7);
    @(posedge clk);
    model[7] = 32'hDEADBEEF;
    #1;
    chk("rdw_post_p1", readData1, 32'hDEADBEEF);
    chk("rdw_post_p2", readData2, 32'hDEADBEEF);
    @(negedge clk);
    write = 1'b0;

    // Mid-stream reset with a write pending; must clear without a clock edge.
    readReg1 = 5'd3;
    readReg2 = 5'd1;
    #1;
    chk("prerst_r3", readData1, 32'h3);
    write       = 1'b1;
    register_no = 5'd3;
    reg_data    = 32'h12345678;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_r3", readData1, 32'h0);
    chk("arst_r1", readData2, 32'h0);
    readReg1 = 5'd7;
    readReg2 = 5'd0;
    #1;
    chk("arst_r7", readData1, 32'h0);
    chk("arst_r0", readData2, 32'h0);
    @(posedge clk);
    #1;
    readReg1 = 5'd3;
    #1;
    chk("arst_wblk", readData1, 32'h0);
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    @(negedge clk);
    write = 1'b0;
    rst_n = 1'b1;

    // Random traffic against the array reference.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      write       = ($urandom_range(0, 3) != 0);
      register_no = 5'($urandom);
      reg_data    = $urandom;
      readReg1    = 5'($urandom);
      readReg2    = ($urandom_range(0, 3) == 0) ? register_no : 5'($urandom);
      #1;
      chk("rnd_p1", readData1, model[readReg1]);
      chk("rnd_p2", readData2, model[readReg2]);
      @(posedge clk);
      if (write) model[register_no] = reg_data;
      #1;
      chk("rnd_post_p1", readData1, model[readReg1]);
      chk("rnd_post_p2", readData2, model[readReg2]);
    end

    @(negedge clk);
    write = 1'b0;
    for (int k = 0; k < 32; k++) rd(5'(k), 5'(31 - k), "final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
